// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/memory-stage arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_ME = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of IDLE cycles in which a pending fetch lost arbitration.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = $clog2(LIMIT + 2);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage,
// one outstanding transaction, with fetch anti-starvation and flush drop.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  me_req,
  input  logic                  me_we,
  input  logic [ADDR_WIDTH-1:0] me_addr,
  input  logic [3:0]            me_wstrb,
  input  logic [DATA_WIDTH-1:0] me_wdata,
  output logic                  me_gnt,
  output logic                  me_rvalid,
  output logic [DATA_WIDTH-1:0] me_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  if_stall,
  output logic                  me_stall
);

  state_e state, state_nxt;
  owner_e owner, owner_nxt;
  logic   drop,  drop_nxt;
  logic   starve_hit;
  logic   sel_if;

  // Memory stage normally wins; a starved fetch gets one guaranteed grant.
  assign sel_if = if_req && (!me_req || starve_hit);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    drop_nxt  = drop;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_wstrb = 4'h0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    me_gnt    = 1'b0;
    if_rvalid = 1'b0;
    me_rvalid = 1'b0;
    case (state)
      IDLE: begin
        // Gating with rst_n keeps the request quiet while reset is held.
        mem_req = rst_n && (if_req || me_req);
        if (!sel_if) begin
          mem_we    = me_we;
          mem_addr  = me_addr;
          mem_wstrb = me_wstrb;
          mem_wdata = me_wdata;
        end
        if (mem_req && mem_ready) begin
          if_gnt    = sel_if;
          me_gnt    = !sel_if;
          owner_nxt = sel_if ? OWN_IF : OWN_ME;
          drop_nxt  = sel_if && if_flush;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (if_flush && (owner == OWN_IF)) begin
          drop_nxt = 1'b1;
        end
        // A flush arriving with the response itself also discards it.
        if (mem_rvalid) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
          if (owner == OWN_ME) begin
            me_rvalid = 1'b1;
          end else begin
            if_rvalid = !(drop || if_flush);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_IF;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      drop  <= drop_nxt;
    end
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      ((state == IDLE) && if_req && !if_gnt),
    .clr      (!if_req || if_gnt),
    .at_limit (starve_hit)
  );

  assign if_rdata = mem_rdata;
  assign me_rdata = mem_rdata;
  assign if_stall = if_req && !if_rvalid;
  assign me_stall = me_req && !me_rvalid;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 32, address width; DATA_WIDTH 32, data width; STARVE_LIMIT 8, consecutive fetch-denied cycles before fetch gets priority.
REQ-002 SHALL have clk input 1: single clock; all state on rising edge.
REQ-003 SHALL have rst_n input 1: asynchronous, active-low reset.
REQ-004 SHALL have if_req input 1: fetch read request; if_addr input ADDR_WIDTH: fetch address.
REQ-005 SHALL have if_flush input 1: pipeline redirect; discard any outstanding fetch response.
REQ-006 SHALL have outputs if_gnt 1 (fetch accepted), if_rvalid 1 (fetch data valid), if_rdata DATA_WIDTH (fetch data).
REQ-007 SHALL have inputs me_req 1, me_we 1 (1 = store), me_addr ADDR_WIDTH, me_wstrb 4 (byte enables), me_wdata DATA_WIDTH.
REQ-008 SHALL have outputs me_gnt 1, me_rvalid 1 (load data or store ack), me_rdata DATA_WIDTH.
REQ-009 SHALL have outputs mem_req 1, mem_we 1, mem_addr ADDR_WIDTH, mem_wstrb 4, mem_wdata DATA_WIDTH; inputs mem_ready 1 (accept), mem_rvalid 1, mem_rdata DATA_WIDTH.
REQ-010 SHALL have outputs if_stall 1 and me_stall 1 toward the pipeline.

Function
REQ-011 SHALL use a two-state FSM: IDLE and BUSY, with at most one outstanding memory transaction.
REQ-012 In IDLE, mem_req SHALL equal if_req OR me_req, and mem_addr/we/wstrb/wdata SHALL come from the selected requester; a fetch drives mem_we=0 and mem_wstrb=0.
REQ-013 Selection SHALL be me over if, except when the starve counter equals STARVE_LIMIT, in which case if wins.
REQ-014 Accept (mem_req AND mem_ready in IDLE) SHALL pulse the winner's gnt in the same cycle, latch owner, and move to BUSY.
REQ-015 In BUSY, mem_req SHALL be 0 and all gnt SHALL be 0; on mem_rvalid, the FSM SHALL return to IDLE, so throughput is at most one transaction per two cycles.
REQ-016 On mem_rvalid in BUSY, the owner's rvalid SHALL be 1 in the same cycle; if_rdata and me_rdata SHALL equal mem_rdata combinationally.
REQ-017 The starve counter SHALL increment, saturating at STARVE_LIMIT, each IDLE cycle with if_req=1 and no if grant, and SHALL clear on if_gnt or if_req=0.
REQ-018 if_flush with owner=IF in BUSY, or in IDLE with same-cycle if_gnt, SHALL set a drop flag; the matching response SHALL then return the FSM to IDLE with if_rvalid=0, and the flag SHALL clear.
REQ-019 if_flush SHALL NOT affect me transactions or an IDLE arbiter with no if grant.
REQ-020 mem_rvalid in IDLE SHALL be ignored (no rvalid to either requester).
REQ-021 if_stall SHALL equal if_req AND NOT if_rvalid; me_stall SHALL equal me_req AND NOT me_rvalid.
REQ-022 Requesters SHALL hold req/addr/data stable until their gnt; the arbiter SHALL NOT check this.

Reset
REQ-023 rst_n low SHALL immediately force FSM=IDLE, owner=IF, starve counter=0, drop flag=0.
REQ-024 During reset, all gnt, rvalid, and mem_req outputs SHALL be 0.
REQ-025 Reset during BUSY SHALL abandon the outstanding transaction; a late mem_rvalid falls under REQ-020.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY), owner enum (OWN_IF, OWN_ME), and the STARVE_LIMIT default.
REQ-027 The saturating starve counter SHALL be the sub-module arb_starve_ctr; everything else SHALL be inline.

Verification
REQ-028 me load 0x100 and if fetch 0x0 requested together, mem_ready=1, response 0xDEADBEEF after 2 cycles -> me_gnt first, me_rvalid with 0xDEADBEEF, then if_gnt.
REQ-029 me_req held high for 8 consecutive grants with if_req high -> 9th grant goes to if; starve counter returns to 0.
REQ-030 Fetch 0x40 granted, if_flush pulsed in BUSY, response 0x13 -> if_rvalid stays 0; the next fetch 0x80 completes normally.
REQ-031 Store me_we=1, wstrb=0x3, wdata=0x1234 -> mem_we=1, mem_wstrb=0x3, mem_wdata=0x1234; ack yields me_rvalid=1 and me_stall drops.
REQ-032 rst_n asserted in BUSY, then mem_rvalid pulsed after release -> no rvalid on either port, FSM in IDLE, mem_req follows requests.
REQ-033 mem_ready=0 for 3 cycles with if_req=1 -> mem_req held 1, no gnt, if_stall=1; grant on the 4th cycle.
